// File: rtl/ss_pop_unit.sv
// Shadow-stack pop (SSPOPCHK): translate SSP, load one XLEN word, compare with the link register.
// Optional SS_POP_ALIGN_CHECK_EN raises a misaligned-load exception for unaligned SSP instead of translating.
module ss_pop_unit #(
    parameter int XLEN               = 64,
    parameter int VLEN               = 39,
    parameter int PLEN               = 56,
    parameter int TRANS_ID_BITS      = 3,
    parameter int DCACHE_INDEX_WIDTH = 12,
    parameter int DCACHE_TAG_WIDTH   = 44
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [VLEN-1:0]               ssp_i,
    input  logic [XLEN-1:0]               link_i,
    input  logic [TRANS_ID_BITS-1:0]      trans_id_i,
    output logic                          translation_req_o,
    output logic [VLEN-1:0]               vaddr_o,
    input  logic [PLEN-1:0]               paddr_i,
    input  logic                          dtlb_hit_i,
    input  logic                          tr_ex_valid_i,
    input  logic [XLEN-1:0]               tr_ex_cause_i,
    output logic                          dreq_o,
    input  logic                          dgnt_i,
    output logic [DCACHE_INDEX_WIDTH-1:0] daddr_index_o,
    output logic [DCACHE_TAG_WIDTH-1:0]   dtag_o,
    output logic                          dtag_valid_o,
    output logic                          dkill_o,
    input  logic                          drvalid_i,
    input  logic [XLEN-1:0]               drdata_i,
    output logic                          valid_o,
    output logic [TRANS_ID_BITS-1:0]      trans_id_o,
    output logic [XLEN-1:0]               result_o,
    output logic                          ex_valid_o,
    output logic [XLEN-1:0]               ex_cause_o,
    output logic [XLEN-1:0]               ex_tval_o,
    output logic                          ssp_we_o,
    output logic [VLEN-1:0]               ssp_o
);

    typedef enum logic [2:0] {IDLE, XLATE, REQ, TAG, WAIT_DATA, DRAIN} state_t;

    state_t                     state;
    logic [VLEN-1:0]            ssp_q;
    logic [XLEN-1:0]            link_q;
    logic [TRANS_ID_BITS-1:0]   id_q;
    logic [PLEN-1:0]            paddr_q;
    logic                       kill_q;
    logic                       misaligned;
    logic                       kill_now;
    logic                       data_match;
    logic [VLEN-1:0]            ssp_next;

`ifdef SS_POP_ALIGN_CHECK_EN
    localparam int OFF_BITS = $clog2(XLEN/8);
    assign misaligned = (ssp_q[OFF_BITS-1:0] != '0);
`else
    assign misaligned = 1'b0;
`endif

    assign ready_o           = (state == IDLE);
    assign translation_req_o = (state == XLATE) && !misaligned;
    assign vaddr_o           = ssp_q;
    assign dreq_o            = (state == REQ);
    assign daddr_index_o     = paddr_q[DCACHE_INDEX_WIDTH-1:0];
    assign dtag_valid_o      = (state == TAG);
    assign dtag_o            = paddr_q[DCACHE_INDEX_WIDTH+DCACHE_TAG_WIDTH-1:DCACHE_INDEX_WIDTH];

    // A flush caught at grant time is remembered so the kill lands with the tag.
    assign kill_now   = kill_q || flush_i;
    assign dkill_o    = ((state == TAG) && kill_now) || ((state == WAIT_DATA) && flush_i);
    assign data_match = (drdata_i == link_q);
    assign ssp_next   = ssp_q + VLEN'(XLEN/8);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ssp_q      <= '0;
            link_q     <= '0;
            id_q       <= '0;
            paddr_q    <= '0;
            kill_q     <= 1'b0;
            valid_o    <= 1'b0;
            trans_id_o <= '0;
            result_o   <= '0;
            ex_valid_o <= 1'b0;
            ex_cause_o <= '0;
            ex_tval_o  <= '0;
            ssp_we_o   <= 1'b0;
            ssp_o      <= '0;
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        ssp_q  <= ssp_i;
                        link_q <= link_i;
                        id_q   <= trans_id_i;
                        kill_q <= 1'b0;
                        state  <= XLATE;
                    end
                end
                XLATE: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (misaligned || tr_ex_valid_i) begin
                        valid_o    <= 1'b1;
                        trans_id_o <= id_q;
                        ex_valid_o <= 1'b1;
                        ex_cause_o <= misaligned ? XLEN'(4) : tr_ex_cause_i;
                        ex_tval_o  <= XLEN'(ssp_q);
                        ssp_we_o   <= 1'b0;
                        state      <= IDLE;
                    end else if (dtlb_hit_i) begin
                        paddr_q <= paddr_i;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (dgnt_i) begin
                        kill_q <= flush_i;
                        state  <= TAG;
                    end else if (flush_i) begin
                        state <= IDLE;
                    end
                end
                TAG, WAIT_DATA: begin
                    if (drvalid_i) begin
                        if (!kill_now) begin
                            valid_o    <= 1'b1;
                            trans_id_o <= id_q;
                            result_o   <= drdata_i;
                            if (data_match) begin
                                ex_valid_o <= 1'b0;
                                ex_cause_o <= '0;
                                ex_tval_o  <= '0;
                                ssp_we_o   <= 1'b1;
                                ssp_o      <= ssp_next;
                            end else begin
                                ex_valid_o <= 1'b1;
                                ex_cause_o <= XLEN'(18);
                                ex_tval_o  <= XLEN'(3);
                                ssp_we_o   <= 1'b0;
                            end
                        end
                        state <= IDLE;
                    end else if (kill_now) begin
                        state <= DRAIN;
                    end else begin
                        state <= WAIT_DATA;
                    end
                end
                DRAIN: begin
                    if (drvalid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_pop_unit.sv
// Bench for ss_pop_unit: directed scenarios with a response scoreboard checked by a monitor.
module tb_ss_pop_unit;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_o;
    logic [38:0] ssp_i;
    logic [63:0] link_i;
    logic [2:0]  trans_id_i;
    logic        translation_req_o;
    logic [38:0] vaddr_o;
    logic [55:0] paddr_i;
    logic        dtlb_hit_i, tr_ex_valid_i;
    logic [63:0] tr_ex_cause_i;
    logic        dreq_o, dgnt_i;
    logic [11:0] daddr_index_o;
    logic [43:0] dtag_o;
    logic        dtag_valid_o, dkill_o, drvalid_i;
    logic [63:0] drdata_i;
    logic        valid_o;
    logic [2:0]  trans_id_o;
    logic [63:0] result_o;
    logic        ex_valid_o;
    logic [63:0] ex_cause_o, ex_tval_o;
    logic        ssp_we_o;
    logic [38:0] ssp_o;

    typedef struct {
        logic [2:0]  id;
        logic        chk_res;
        logic [63:0] result;
        logic        exv;
        logic [63:0] cause;
        logic [63:0] tval;
        logic        we;
        logic [38:0] ssp;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    ss_pop_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .ssp_i(ssp_i), .link_i(link_i), .trans_id_i(trans_id_i),
        .translation_req_o(translation_req_o), .vaddr_o(vaddr_o), .paddr_i(paddr_i),
        .dtlb_hit_i(dtlb_hit_i), .tr_ex_valid_i(tr_ex_valid_i), .tr_ex_cause_i(tr_ex_cause_i),
        .dreq_o(dreq_o), .dgnt_i(dgnt_i), .daddr_index_o(daddr_index_o), .dtag_o(dtag_o),
        .dtag_valid_o(dtag_valid_o), .dkill_o(dkill_o), .drvalid_i(drvalid_i), .drdata_i(drdata_i),
        .valid_o(valid_o), .trans_id_o(trans_id_o), .result_o(result_o), .ex_valid_o(ex_valid_o),
        .ex_cause_o(ex_cause_o), .ex_tval_o(ex_tval_o), .ssp_we_o(ssp_we_o), .ssp_o(ssp_o)
    );

    always #5 clk_i = ~clk_i;

    // Every response pulse must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: got valid_o id=%0d, required no response", trans_id_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (trans_id_o !== e.id || ex_valid_o !== e.exv || ssp_we_o !== e.we ||
                    (e.chk_res && result_o !== e.result) ||
                    (e.exv && (ex_cause_o !== e.cause || ex_tval_o !== e.tval)) ||
                    (e.we && ssp_o !== e.ssp)) begin
                    bad++;
                    $display("FAIL rsp: got id=%0d res=%h exv=%b cause=%0d tval=%h we=%b ssp=%h, required id=%0d res=%h exv=%b cause=%0d tval=%h we=%b ssp=%h",
                             trans_id_o, result_o, ex_valid_o, ex_cause_o, ex_tval_o, ssp_we_o, ssp_o,
                             e.id, e.result, e.exv, e.cause, e.tval, e.we, e.ssp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        flush_i = 0; valid_i = 0; dtlb_hit_i = 0; tr_ex_valid_i = 0;
        dgnt_i = 0; drvalid_i = 0; tr_ex_cause_i = '0; paddr_i = '0; drdata_i = '0;
    endtask

    task automatic start_pop(input logic [38:0] s, input logic [63:0] l, input logic [2:0] id);
        valid_i = 1; ssp_i = s; link_i = l; trans_id_i = id;
        tick();
        valid_i = 0;
    endtask

    // Full pop with TLB hit, immediate grant and data in the tag cycle.
    task automatic run_pop(input logic [38:0] s, input logic [63:0] l, input logic [63:0] mem, input logic [2:0] id);
        exp_t e;
        start_pop(s, l, id);
        total++;
        if (translation_req_o !== 1'b1 || vaddr_o !== s) begin
            bad++; $display("FAIL xlate: got req=%b vaddr=%h, required 1 %h", translation_req_o, vaddr_o, s);
        end
        dtlb_hit_i = 1; paddr_i = {17'b0, s};
        tick();
        dtlb_hit_i = 0;
        total++;
        if (dreq_o !== 1'b1 || daddr_index_o !== s[11:0]) begin
            bad++; $display("FAIL req: got dreq=%b idx=%h, required 1 %h", dreq_o, daddr_index_o, s[11:0]);
        end
        dgnt_i = 1;
        tick();
        dgnt_i = 0;
        total++;
        if (dtag_valid_o !== 1'b1 || dtag_o !== {17'b0, s[38:12]} || dkill_o !== 1'b0) begin
            bad++; $display("FAIL tag: got tv=%b tag=%h kill=%b, required 1 %h 0", dtag_valid_o, dtag_o, dkill_o, {17'b0, s[38:12]});
        end
        e.id = id; e.chk_res = 1; e.result = mem; e.exv = (mem != l);
        e.cause = 64'd18; e.tval = 64'd3; e.we = (mem == l); e.ssp = s + 39'd8;
        q.push_back(e);
        drvalid_i = 1; drdata_i = mem;
        tick();
        drvalid_i = 0;
        total++;
        if (valid_o !== 1'b1) begin
            bad++; $display("FAIL latency_t4: got valid_o=%b, required 1", valid_o);
        end
        tick();
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL after_rsp: got valid=%b ready=%b, required 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1; clr(); ssp_i = '0; link_i = '0; trans_id_i = '0;
        tick(); tick();
        rst_i = 0;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || dreq_o !== 1'b0 || translation_req_o !== 1'b0 ||
            ssp_we_o !== 1'b0 || ex_valid_o !== 1'b0 || result_o !== 64'd0 || ssp_o !== 39'd0) begin
            bad++; $display("FAIL reset: got ready=%b valid=%b dreq=%b treq=%b we=%b exv=%b res=%h ssp=%h, required 1 and zeros",
                            ready_o, valid_o, dreq_o, translation_req_o, ssp_we_o, ex_valid_o, result_o, ssp_o);
        end
    endtask

    task automatic test_match();
        run_pop(39'h1000, 64'h8000_0040, 64'h8000_0040, 3'd1);
        total++;
        if (ssp_o !== 39'h1008 || ssp_we_o !== 1'b1 || ex_valid_o !== 1'b0) begin
            bad++; $display("FAIL match_hold: got ssp=%h we=%b exv=%b, required 1008 1 0", ssp_o, ssp_we_o, ex_valid_o);
        end
    endtask

    task automatic test_mismatch();
        run_pop(39'h1000, 64'h8000_0040, 64'h8000_0044, 3'd2);
    endtask

    task automatic test_wrap();
        run_pop(39'h7F_FFFF_FFF8, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 3'd3);
        total++;
        if (ssp_o !== 39'd0) begin
            bad++; $display("FAIL wrap: got ssp=%h, required 0", ssp_o);
        end
    endtask

    task automatic test_tr_ex();
        exp_t e;
        start_pop(39'h2000, 64'h1234, 3'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dreq_o !== 1'b0 || translation_req_o !== 1'b1 || valid_o !== 1'b0) begin
                bad++; $display("FAIL tlb_miss: got dreq=%b treq=%b valid=%b, required 0 1 0", dreq_o, translation_req_o, valid_o);
            end
        end
        e.id = 3'd4; e.chk_res = 0; e.result = '0; e.exv = 1; e.cause = 64'd13; e.tval = 64'h2000; e.we = 0; e.ssp = '0;
        q.push_back(e);
        tr_ex_valid_i = 1; tr_ex_cause_i = 64'd13;
        tick();
        clr();
        total++;
        if (valid_o !== 1'b1 || dreq_o !== 1'b0) begin
            bad++; $display("FAIL tr_ex_rsp: got valid=%b dreq=%b, required 1 0", valid_o, dreq_o);
        end
        tick();
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || dreq_o !== 1'b0) begin
            bad++; $display("FAIL tr_ex_after: got valid=%b ready=%b dreq=%b, required 0 1 0", valid_o, ready_o, dreq_o);
        end
    endtask

    task automatic test_flush_drain();
        start_pop(39'h3000, 64'h55, 3'd5);
        dtlb_hit_i = 1; paddr_i = {17'b0, 39'h3000};
        tick();
        dtlb_hit_i = 0; dgnt_i = 1;
        tick();
        dgnt_i = 0; flush_i = 1;
        #1;
        total++;
        if (dtag_valid_o !== 1'b1 || dkill_o !== 1'b1) begin
            bad++; $display("FAIL flush_kill: got tv=%b kill=%b, required 1 1", dtag_valid_o, dkill_o);
        end
        tick();
        flush_i = 0;
        total++;
        if (ready_o !== 1'b0 || dkill_o !== 1'b0) begin
            bad++; $display("FAIL drain: got ready=%b kill=%b, required 0 0", ready_o, dkill_o);
        end
        tick();
        drvalid_i = 1; drdata_i = 64'h55;
        tick();
        drvalid_i = 0;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++; $display("FAIL drain_exit: got ready=%b valid=%b, required 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_flush_idle();
        valid_i = 1; flush_i = 1; ssp_i = 39'h4000; trans_id_i = 3'd6;
        tick();
        clr();
        total++;
        if (ready_o !== 1'b1 || translation_req_o !== 1'b0) begin
            bad++; $display("FAIL flush_idle: got ready=%b treq=%b, required 1 0", ready_o, translation_req_o);
        end
    endtask

    task automatic test_delayed();
        exp_t e;
        start_pop(39'h5008, 64'hCAFE, 3'd7);
        dtlb_hit_i = 1; paddr_i = {17'b0, 39'h5008};
        tick();
        dtlb_hit_i = 0;
        tick(); tick();
        total++;
        if (dreq_o !== 1'b1) begin
            bad++; $display("FAIL req_hold: got dreq=%b, required 1", dreq_o);
        end
        dgnt_i = 1;
        tick();
        dgnt_i = 0;
        tick(); tick();
        total++;
        if (dtag_valid_o !== 1'b0 || ready_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL wait_data: got tv=%b ready=%b valid=%b, required 0 0 0", dtag_valid_o, ready_o, valid_o);
        end
        e.id = 3'd7; e.chk_res = 1; e.result = 64'hCAFE; e.exv = 0; e.cause = '0; e.tval = '0; e.we = 1; e.ssp = 39'h5010;
        q.push_back(e);
        drvalid_i = 1; drdata_i = 64'hCAFE;
        tick();
        drvalid_i = 0;
        total++;
        if (valid_o !== 1'b1) begin
            bad++; $display("FAIL delayed_rsp: got valid=%b, required 1", valid_o);
        end
        tick();
    endtask

    task automatic test_reset_wait();
        start_pop(39'h6000, 64'h77, 3'd2);
        dtlb_hit_i = 1; paddr_i = {17'b0, 39'h6000};
        tick();
        dtlb_hit_i = 0; dgnt_i = 1;
        tick();
        dgnt_i = 0;
        tick();
        rst_i = 1;
        #1;
        total++;
        if (dkill_o !== 1'b0) begin
            bad++; $display("FAIL reset_nokill: got kill=%b, required 0", dkill_o);
        end
        tick();
        rst_i = 0;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || ssp_o !== 39'd0 || ssp_we_o !== 1'b0 ||
            result_o !== 64'd0 || trans_id_o !== 3'd0 || vaddr_o !== 39'd0 || dtag_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got ready=%b valid=%b ssp=%h we=%b res=%h id=%0d vaddr=%h tv=%b, required 1 and zeros",
                            ready_o, valid_o, ssp_o, ssp_we_o, result_o, trans_id_o, vaddr_o, dtag_valid_o);
        end
        drvalid_i = 1; drdata_i = 64'h77;
        tick();
        drvalid_i = 0;
        tick();
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++; $display("FAIL late_rvalid: got ready=%b valid=%b, required 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_align();
`ifdef SS_POP_ALIGN_CHECK_EN
        exp_t e;
        start_pop(39'h1004, 64'h1, 3'd3);
        total++;
        if (translation_req_o !== 1'b0 || dreq_o !== 1'b0) begin
            bad++; $display("FAIL align_xlate: got treq=%b dreq=%b, required 0 0", translation_req_o, dreq_o);
        end
        e.id = 3'd3; e.chk_res = 0; e.result = '0; e.exv = 1; e.cause = 64'd4; e.tval = 64'h1004; e.we = 0; e.ssp = '0;
        q.push_back(e);
        tick();
        total++;
        if (valid_o !== 1'b1 || dreq_o !== 1'b0) begin
            bad++; $display("FAIL align_rsp: got valid=%b dreq=%b, required 1 0", valid_o, dreq_o);
        end
        tick();
`else
        start_pop(39'h1004, 64'h1, 3'd3);
        total++;
        if (translation_req_o !== 1'b1) begin
            bad++; $display("FAIL noalign_xlate: got treq=%b, required 1", translation_req_o);
        end
        flush_i = 1;
        tick();
        flush_i = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_tr_ex();
        test_flush_drain();
        test_wrap();
        test_flush_idle();
        test_delayed();
        test_align();
        test_reset_wait();
        tick();
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL pending: got %0d responses outstanding, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
